// File: rtl/adder_operand_loader.sv
// Byte-stream loader that assembles four 8-bit operands and holds them for the adder core.
// Define ADDER_OPERAND_CHECKSUM_EN to require a trailing XOR checksum byte per set.
module adder_operand_loader (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] a,
  output logic [7:0] b,
  output logic [7:0] c,
  output logic [7:0] d,
  output logic       ops_valid,
  input  logic       ops_ready,
  output logic [7:0] set_count,
  output logic       chk_err
);

`ifdef ADDER_OPERAND_CHECKSUM_EN
  typedef enum logic [1:0] {StFill = 2'd0, StCheck = 2'd1, StPresent = 2'd2} state_e;
`else
  typedef enum logic [1:0] {StFill = 2'd0, StPresent = 2'd2} state_e;
`endif

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] a_q, b_q, c_q, d_q;
  logic [7:0] cnt_q, cnt_d;
  logic       ops_valid_q;
  logic       chk_err_q, chk_err_d;
  logic       wr_en;
  logic       accept;

  // Ready is forced low while reset is held so nothing is taken during reset.
  always_comb begin
    in_ready = 1'b0;
    if (!reset) begin
`ifdef ADDER_OPERAND_CHECKSUM_EN
      in_ready = (state_q == StFill) || (state_q == StCheck);
`else
      in_ready = (state_q == StFill);
`endif
    end
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    wr_en     = 1'b0;
    chk_err_d = 1'b0;
    case (state_q)
      StFill: begin
        if (accept) begin
          wr_en = 1'b1;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
`ifdef ADDER_OPERAND_CHECKSUM_EN
            state_d = StCheck;
`else
            state_d = StPresent;
`endif
          end
        end
      end
`ifdef ADDER_OPERAND_CHECKSUM_EN
      StCheck: begin
        if (accept) begin
          if (in_data == (a_q ^ b_q ^ c_q ^ d_q)) begin
            state_d = StPresent;
          end else begin
            state_d   = StFill;
            chk_err_d = 1'b1;
          end
        end
      end
`endif
      StPresent: begin
        if (ops_ready) begin
          state_d = StFill;
          cnt_d   = cnt_q + 8'd1;
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StFill;
      idx_q       <= 2'd0;
      cnt_q       <= 8'd0;
      ops_valid_q <= 1'b0;
      chk_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      ops_valid_q <= (state_d == StPresent);
      chk_err_q   <= chk_err_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q <= 8'd0;
      b_q <= 8'd0;
      c_q <= 8'd0;
      d_q <= 8'd0;
    end else if (wr_en) begin
      case (idx_q)
        2'd0:    a_q <= in_data;
        2'd1:    b_q <= in_data;
        2'd2:    c_q <= in_data;
        default: d_q <= in_data;
      endcase
    end
  end

  assign a         = a_q;
  assign b         = b_q;
  assign c         = c_q;
  assign d         = d_q;
  assign ops_valid = ops_valid_q;
  assign set_count = cnt_q;
  assign chk_err   = chk_err_q;

endmodule

// File: tb/tb_adder_operand_loader.sv
// Directed self-checking bench for adder_operand_loader; follows ADDER_OPERAND_CHECKSUM_EN.
module tb_adder_operand_loader;

  logic       clk;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a, b, c, d;
  logic       ops_valid;
  logic       ops_ready;
  logic [7:0] set_count;
  logic       chk_err;

  int total;
  int bad;
  int rises;
  int last_rise;
  logic prev_v;
  logic [7:0] gap_bytes [5];

`ifdef ADDER_OPERAND_CHECKSUM_EN
  localparam int NumBytes = 5;
  localparam int Period   = 6;
`else
  localparam int NumBytes = 4;
  localparam int Period   = 5;
`endif

  adder_operand_loader dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .ops_valid (ops_valid),
    .ops_ready (ops_ready),
    .set_count (set_count),
    .chk_err   (chk_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one byte; returns at the falling edge after the accepting rising edge.
  task automatic push(input logic [7:0] v);
    in_valid = 1'b1;
    in_data  = v;
    @(negedge clk);
  endtask

  task automatic feed_set(input logic [7:0] p, input logic [7:0] q, input logic [7:0] r,
                          input logic [7:0] s);
    push(p);
    push(q);
    push(r);
    push(s);
`ifdef ADDER_OPERAND_CHECKSUM_EN
    push(p ^ q ^ r ^ s);
`endif
    in_valid = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    clk = 1'b0;
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    ops_ready = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_ops_valid", ops_valid, 0);
    check("rst_a", a, 0);
    check("rst_d", d, 0);
    check("rst_set_count", set_count, 0);
    check("rst_chk_err", chk_err, 0);
    reset = 1'b0;
    #1;
    check("rel_in_ready", in_ready, 1);

    // Basic set with ops_ready already high
    feed_set(8'h11, 8'h22, 8'h33, 8'h44);
    check("t1_ops_valid", ops_valid, 1);
    check("t1_in_ready", in_ready, 0);
    check("t1_a", a, 8'h11);
    check("t1_b", b, 8'h22);
    check("t1_c", c, 8'h33);
    check("t1_d", d, 8'h44);
    check("t1_cnt_before", set_count, 0);
    check("t1_chk_err", chk_err, 0);
    @(negedge clk);
    check("t1_ops_valid_drop", ops_valid, 0);
    check("t1_in_ready_back", in_ready, 1);
    check("t1_cnt", set_count, 1);

    // Backpressure: set held for 10 cycles while extra bytes are offered
    ops_ready = 1'b0;
    feed_set(8'hA1, 8'hB2, 8'hC3, 8'hD4);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hEE;
      check("bp_ops_valid", ops_valid, 1);
      check("bp_a", a, 8'hA1);
      check("bp_d", d, 8'hD4);
      check("bp_in_ready", in_ready, 0);
      check("bp_cnt", set_count, 1);
      @(negedge clk);
    end
    ops_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_ops_valid_drop", ops_valid, 0);
    check("bp_cnt", set_count, 2);
    check("bp_in_ready", in_ready, 1);
    @(negedge clk);
    check("bp_single_inc", set_count, 2);

    // Gaps between every byte; the byte offered during the handshake must not have landed
    ops_ready = 1'b0;
    gap_bytes[0] = 8'h5A;
    gap_bytes[1] = 8'hA5;
    gap_bytes[2] = 8'h3C;
    gap_bytes[3] = 8'hC3;
    gap_bytes[4] = 8'h00;
    for (int i = 0; i < NumBytes; i++) begin
      push(gap_bytes[i]);
      in_valid = 1'b0;
      check("gap_ops_valid", ops_valid, (i == NumBytes - 1) ? 1 : 0);
      if (i != NumBytes - 1) begin
        @(negedge clk);
        check("gap_idle_ops_valid", ops_valid, 0);
      end
    end
    check("gap_a", a, 8'h5A);
    check("gap_b", b, 8'hA5);
    check("gap_c", c, 8'h3C);
    check("gap_d", d, 8'hC3);
    ops_ready = 1'b1;
    @(negedge clk);
    check("gap_cnt", set_count, 3);

    // Reset in the middle of a set
    push(8'hAA);
    push(8'hBB);
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_a", a, 0);
    check("mid_rst_cnt", set_count, 0);
    @(negedge clk);
    check("mid_rst_ops_valid", ops_valid, 0);
    reset = 1'b0;
    ops_ready = 1'b0;
    feed_set(8'h01, 8'h02, 8'h03, 8'h04);
    check("mid_ops_valid", ops_valid, 1);
    check("mid_a", a, 8'h01);
    check("mid_b", b, 8'h02);
    check("mid_c", c, 8'h03);
    check("mid_d", d, 8'h04);
    ops_ready = 1'b1;
    @(negedge clk);
    check("mid_cnt", set_count, 1);

    // 256 back-to-back sets of zeros: spacing and counter wrap
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    in_data = 8'h00;
    in_valid = 1'b1;
    rises = 0;
    last_rise = 0;
    prev_v = 1'b0;
    for (int cyc = 0; cyc < 256 * 8 && rises < 256; cyc++) begin
      @(negedge clk);
      if (ops_valid && !prev_v) begin
        if (rises > 0) check("b2b_spacing", cyc - last_rise, Period);
        last_rise = cyc;
        rises++;
        if (rises == 256) in_valid = 1'b0;
      end
      prev_v = ops_valid;
    end
    check("b2b_rises", rises, 256);
    @(negedge clk);
    check("b2b_wrap_cnt", set_count, 0);
    check("b2b_ops_valid", ops_valid, 0);

`ifdef ADDER_OPERAND_CHECKSUM_EN
    // Checksum match then mismatch
    ops_ready = 1'b0;
    push(8'h0F);
    push(8'hF0);
    push(8'hAA);
    push(8'h55);
    push(8'h00);
    in_valid = 1'b0;
    check("ck_ok_ops_valid", ops_valid, 1);
    check("ck_ok_chk_err", chk_err, 0);
    ops_ready = 1'b1;
    @(negedge clk);
    check("ck_ok_cnt", set_count, 1);
    push(8'h0F);
    push(8'hF0);
    push(8'hAA);
    push(8'h55);
    push(8'h01);
    in_valid = 1'b0;
    check("ck_bad_chk_err", chk_err, 1);
    check("ck_bad_ops_valid", ops_valid, 0);
    check("ck_bad_in_ready", in_ready, 1);
    @(negedge clk);
    check("ck_bad_pulse_end", chk_err, 0);
    check("ck_bad_ops_valid2", ops_valid, 0);
    check("ck_bad_cnt", set_count, 1);
`else
    check("nock_chk_err", chk_err, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_operand_loader.md
# adder_operand_loader

Upstream feeder for the four-operand adder core. Accepts a byte stream on a valid/ready handshake, assembles operands a, b, c, d in that order, then presents them as one stable set with a valid flag until the adder side acknowledges. Counts delivered sets. Optionally verifies a trailing XOR checksum byte.

## Interface

Parameters:
- none; operand width fixed at 8 bits, operand count fixed at 4.

Ports:
- clk  in  1  single clock, all state rising-edge.
- reset  in  1  asynchronous, active-high; clears all state immediately, released synchronously by system.
- in_data  in  8  operand byte.
- in_valid  in  1  in_data valid this cycle.
- in_ready  out  1  loader can accept a byte; byte taken on in_valid && in_ready at clk edge.
- a, b, c, d  out  8 each  assembled operands, adder inputs.
- ops_valid  out  1  a..d form a complete, stable set.
- ops_ready  in  1  adder side consumes the set when high with ops_valid.
- set_count  out  8  number of sets consumed, modulo 256.
- chk_err  out  1  one-cycle pulse on checksum mismatch (tied 0 when checksum disabled).

## Operation

- FSM states: FILL, CHECK (checksum build only), PRESENT.
- Byte index idx (2 bits) selects destination register: 0→a, 1→b, 2→c, 3→d.
- FILL: in_ready=1. Each accepted byte written to operand[idx], idx increments. Accept with idx=3: go to CHECK (checksum build) or PRESENT, idx→0.
- CHECK: in_ready=1. Accepted byte compared with a^b^c^d. Match: →PRESENT. Mismatch: chk_err=1 for the following cycle, →FILL, set discarded (ops_valid never asserted).
- PRESENT: in_ready=0, ops_valid=1, a..d held constant. On ops_valid && ops_ready: →FILL, set_count+1 (255 wraps to 0).
- in_valid while in_ready=0 ignored; source must hold its byte.
- in_valid low in FILL/CHECK: no state change, partial set retained indefinitely.
- a..d retain last written values outside PRESENT; only meaningful while ops_valid=1.
- No same-cycle pass-through: byte offered in the ops_ready handshake cycle is not accepted.

## Timing

- Reset values: a=b=c=d=0, ops_valid=0, set_count=0, chk_err=0, state=FILL, idx=0; in_ready=0 while reset high, 1 in first cycle after release.
- Reset mid-set or during PRESENT: partial/presented set dropped, counter cleared; no ops_valid glitch.
- Latency: 4th byte (or checksum byte) accepted at edge N → ops_valid=1 from cycle after edge N.
- Handshake at edge M → ops_valid=0 and in_ready=1 from cycle after M.
- Max throughput: one set per 5 cycles (6 with checksum) under back-to-back in_valid and ops_ready held high.
- chk_err asserted exactly one cycle, coincident with return to FILL.
- All outputs registered except in_ready (decoded from state and reset).

## Configuration

- Macro ADDER_OPERAND_CHECKSUM_EN.
- Defined: CHECK state built; each set is 5 bytes, 5th = a^b^c^d; mismatch pulses chk_err and drops the set, set_count unchanged.
- Undefined: CHECK state absent; 4-byte sets go FILL→PRESENT directly; chk_err tied 0.

## Test plan

- Reset release, stream 0x11,0x22,0x33,0x44 with ops_ready=1 → ops_valid one cycle, a=0x11 b=0x22 c=0x33 d=0x44, set_count=1, in_ready back to 1 next cycle.
- Backpressure: ops_ready=0 for 10 cycles after set → ops_valid and a..d stable, in_ready=0, extra in_valid bytes not consumed; raise ops_ready → single set_count increment.
- Gaps: in_valid toggled low between every byte → same operands captured, ops_valid only after 4th accepted byte.
- Reset asserted after 2 bytes, then full set 0x01,0x02,0x03,0x04 → a=0x01 (not prior bytes), set_count=1.
- 256 sets back-to-back → set_count wraps to 0; 5-cycle spacing of ops_valid.
- Checksum build: 0x0F,0xF0,0xAA,0x55,0x00 → PRESENT; same operands with 0x01 → chk_err pulse, no ops_valid, set_count unchanged.
